weight_buffer_loader: RTL

//  Upstream stage of the weight buffer array. Accepts a valid/ready stream of

---
 rtl/weight_buffer_loader.sv | 160 ++++++++++++++++
 1 files changed

// File: rtl/weight_buffer_loader.sv
// weight_buffer_loader
// Takes a valid/ready stream of weight words and writes them into the weight
// buffer array through its port-A write interface. Words fill kernel 0..K-1 of
// bank 0, then bank 1, and so on up to bank B-1. After the last write the
// loader pulses done and holds tile_valid until the next tile load begins.
//
// Handshake: a word transfers on a rising clock edge when s_valid and s_ready
// are both high. s_ready is high only while loading. s_data is ignored when
// s_valid is low. An accepted word appears on wr_en/wr_addr/wr_data one cycle
// later, from registers.
module weight_buffer_loader #(
    parameter int TN         = 4,
    parameter int TM         = 16,
    parameter int DATA_WIDTH = 64,
    parameter int ADDR_WIDTH = 4,
    parameter int ADDR_EXT   = 3
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           start,
    input  logic [ADDR_EXT-1:0]            cfg_banks,
    input  logic [ADDR_WIDTH:0]            cfg_kernels,
    input  logic                           s_valid,
    output logic                           s_ready,
    input  logic [DATA_WIDTH-1:0]          s_data,
    output logic                           wr_en,
    output logic [ADDR_EXT+ADDR_WIDTH-1:0] wr_addr,
    output logic [DATA_WIDTH-1:0]          wr_data,
    output logic                           busy,
    output logic                           done,
    output logic                           tile_valid,
    output logic [1:0]                     dbg_state
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        LOAD  = 2'd1,
        FLUSH = 2'd2
    } state_t;

    localparam logic [ADDR_EXT-1:0] TN_V = ADDR_EXT'(TN);
    localparam logic [ADDR_WIDTH:0] TM_V = (ADDR_WIDTH + 1)'(TM);

    state_t                state;
    state_t                state_n;

    logic [ADDR_EXT-1:0]   banks_cl;
    logic [ADDR_WIDTH:0]   kernels_cl;
    logic                  cfg_zero;

    // Final bank index and final kernel index of the tile, latched at start.
    logic [ADDR_EXT-1:0]   bank_last;
    logic [ADDR_WIDTH:0]   kern_last;
    logic [ADDR_EXT-1:0]   bank_cnt;
    logic [ADDR_WIDTH-1:0] kern_cnt;

    logic                  accept;
    logic                  last_kern;
    logic                  last_bank;

    assign dbg_state = state;
    assign accept    = s_valid & s_ready;
    assign last_kern = ({1'b0, kern_cnt} == kern_last);
    assign last_bank = (bank_cnt == bank_last);

    // Clamp the requested tile shape to the physical array, and flag an empty tile.
    always_comb begin
        banks_cl   = (cfg_banks > TN_V) ? TN_V : cfg_banks;
        kernels_cl = (cfg_kernels > TM_V) ? TM_V : cfg_kernels;
        cfg_zero   = (banks_cl == '0) || (kernels_cl == '0);
    end

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_n;
        end
    end

    // Next-state logic and the stream/status outputs decoded from state.
    always_comb begin
        state_n = state;
        s_ready = 1'b0;
        busy    = 1'b0;
        done    = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    state_n = cfg_zero ? FLUSH : LOAD;
                end
            end
            LOAD: begin
                s_ready = 1'b1;
                busy    = 1'b1;
                if (accept && last_kern && last_bank) begin
                    state_n = FLUSH;
                end
            end
            FLUSH: begin
                busy    = 1'b1;
                done    = 1'b1;
                state_n = IDLE;
            end
            default: begin
                state_n = IDLE;
            end
        endcase
    end

    // Latch the tile shape on start and walk kernel/bank counters on each accept.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bank_cnt  <= '0;
            kern_cnt  <= '0;
            bank_last <= '0;
            kern_last <= '0;
        end else if (state == IDLE && start) begin
            bank_cnt  <= '0;
            kern_cnt  <= '0;
            bank_last <= banks_cl - ADDR_EXT'(1);
            kern_last <= kernels_cl - (ADDR_WIDTH + 1)'(1);
        end else if (accept) begin
            if (last_kern) begin
                kern_cnt <= '0;
                bank_cnt <= bank_cnt + ADDR_EXT'(1);
            end else begin
                kern_cnt <= kern_cnt + ADDR_WIDTH'(1);
            end
        end
    end

    // Register each accepted word onto the array write port; address/data hold on stalls.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_en   <= 1'b0;
            wr_addr <= '0;
            wr_data <= '0;
        end else begin
            wr_en <= accept;
            if (accept) begin
                wr_addr <= {bank_cnt, kern_cnt};
                wr_data <= s_data;
            end
        end
    end

    // tile_valid drops when a new load starts and rises as the loader leaves FLUSH.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tile_valid <= 1'b0;
        end else if (state == IDLE && start) begin
            tile_valid <= 1'b0;
        end else if (state == FLUSH) begin
            tile_valid <= 1'b1;
        end
    end

endmodule
